// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Arbitrates two register-file write requesters (req0 = ALU writeback,
// req1 = load writeback) onto a single write port with one cycle of latency.
// It also tracks a per-register pending ("busy") scoreboard. A reserve sets
// a bit, and an accepted write clears it.
//
// Parameters:
//   PRIORITY_MODE  0 = round-robin on ties, 1 = req0 always wins ties
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   reqN_valid/reg/data, reqN_ready    write requesters (N = 0, 1)
//   rsv_valid, rsv_reg                 reserve a destination register
//   busy[31:0]                         per-register pending flags
//   write_reg, write_data              register file write index and data
//   signal_reg_write                   register file write enable
//   grant_id                           which requester drives write_*
module regfile_write_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [4:0]  req0_reg,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_reg,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_reg,
    output logic [31:0] busy,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        signal_reg_write,
    output logic        grant_id
);

    // 1 = req1 was granted most recently, so req0 wins the next tie.
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [4:0]  accept_reg;
    logic [31:0] accept_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_next;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (PRIORITY_MODE == 1) begin
                grant0 = req0_valid;
                grant1 = req1_valid & ~req0_valid;
            end else begin
                grant0 = req0_valid & (~req1_valid | last_grant);
                grant1 = req1_valid & (~req0_valid | ~last_grant);
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        accept      = grant0 | grant1;
        accept_reg  = grant1 ? req1_reg  : req0_reg;
        accept_data = grant1 ? req1_data : req0_data;
    end

    // Set is applied after clear, so a reserve and a write to the same
    // register at the same edge leave the register pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid && (rsv_reg != 5'd0)) begin
            set_mask[rsv_reg] = 1'b1;
        end
        if (accept && (accept_reg != 5'd0)) begin
            clr_mask[accept_reg] = 1'b1;
        end
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant       <= 1'b1;
            busy             <= '0;
            write_reg        <= '0;
            write_data       <= '0;
            grant_id         <= 1'b0;
            signal_reg_write <= 1'b0;
        end else begin
            busy <= busy_next;
            if (accept) begin
                last_grant <= grant1;
                write_reg  <= accept_reg;
                write_data <= accept_data;
                grant_id   <= grant1;
                // Register 0 is hardwired zero. The request is consumed,
                // but the register file sees no write for it.
                signal_reg_write <= (accept_reg != 5'd0);
            end else begin
                signal_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: PRIORITY_MODE, default 0, meaning 0 = round-robin between requesters, 1 = fixed priority with req0 always first.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 Port: req0_reg  input  5  destination register index for requester 0.
REQ-006 Port: req0_data  input  32  write data for requester 0.
REQ-007 Port: req0_ready  output  1  requester 0 write accepted this cycle.
REQ-008 Port: req1_valid, req1_reg, req1_data, req1_ready  same directions and widths as REQ-004..007, for requester 1 (load writeback).
REQ-009 Port: rsv_valid  input  1  reserve a destination register as pending.
REQ-010 Port: rsv_reg  input  5  register index to reserve.
REQ-011 Port: busy  output  32  per-register pending flag; bit n set = register n awaits a write.
REQ-012 Port: write_reg  output  5  register file write index.
REQ-013 Port: write_data  output  32  register file write data.
REQ-014 Port: signal_reg_write  output  1  register file write enable.
REQ-015 Port: grant_id  output  1  source of the current write_* outputs: 0 = req0, 1 = req1.

Function
REQ-016 The block SHALL accept at most one request per cycle; a request is accepted when reqN_valid and reqN_ready are both 1 in the same cycle.
REQ-017 reqN_ready SHALL be combinational from valid inputs and arbiter state; it SHALL never be 1 while reqN_valid is 0.
REQ-018 Only one requester valid: that requester SHALL be granted.
REQ-019 Both valid with PRIORITY_MODE=0: the requester not granted most recently SHALL be granted. The last-grant pointer SHALL update only on an accepted request.
REQ-020 Both valid with PRIORITY_MODE=1: req0 SHALL be granted.
REQ-021 Latency SHALL be 1 cycle: an accepted request at edge k SHALL drive write_reg, write_data, grant_id and signal_reg_write=1 during the cycle after edge k.
REQ-022 No request accepted: signal_reg_write SHALL be 0 the next cycle; write_reg, write_data and grant_id SHALL hold their previous values.
REQ-023 A request with reqN_reg=0 SHALL be accepted (ready=1), but signal_reg_write SHALL remain 0 for it, because register 0 is hardwired zero.
REQ-024 rsv_valid=1 with rsv_reg!=0 SHALL set busy[rsv_reg] at the next edge. rsv_reg=0 SHALL be ignored.
REQ-025 An accepted request with reg r!=0 SHALL clear busy[r] at the same edge that loads the write outputs.
REQ-026 Reserve and clear of the same register at the same edge: set SHALL win, and busy[r] SHALL be 1.
REQ-027 Both requesters valid with the same register index: each SHALL be served in arbitration order. No merging or dropping SHALL occur.
REQ-028 busy[0] SHALL always be 0.
REQ-029 An accept of a register whose busy bit is 0 is legal; the bit SHALL stay 0.

Reset
REQ-030 While reset=1 at an edge, the following SHALL apply at that edge:
  - signal_reg_write=0, write_reg=0, write_data=0, grant_id=0, busy=0;
  - last-grant pointer set so that req1 is considered last granted (req0 wins the first tie).
REQ-031 During a reset cycle req0_ready and req1_ready SHALL be 0, and no reserve SHALL take effect.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight write: signal_reg_write SHALL be 0 in the cycle after the reset edge.

Verification
REQ-033 Reset, then req0_valid=1, reg=3, data=0xCE7FFFF0 -> req0_ready=1 in the same cycle; next cycle signal_reg_write=1, write_reg=3, write_data=0xCE7FFFF0, grant_id=0.
REQ-034 PRIORITY_MODE=0, both valid for 4 cycles (req0 reg=1, req1 reg=2) -> grants 0,1,0,1; write_reg 1,2,1,2 one cycle later.
REQ-035 PRIORITY_MODE=1, both valid for 3 cycles -> req0 granted all 3 cycles; req1_ready=0 throughout.
REQ-036 rsv_valid=1, rsv_reg=5 -> busy=0x00000020 next cycle; then req1 write reg=5 accepted -> busy=0 at the write-output edge. Then reserve 5 and accept a write to 5 at the same edge -> busy[5]=1.
REQ-037 req0 write with reg=0, data=0xFFFFFFFF -> req0_ready=1, signal_reg_write=0 next cycle. Also rsv_reg=0 -> busy stays 0.
REQ-038 Accept a write, then assert reset on the next edge -> signal_reg_write=0 and busy=0 after that edge; the first tie after reset grants req0.
